// File: rtl/cpu_load_sequencer.sv
// Boot/run controller: streams a framed program into the CPU memories, runs it R+1 cycles, then reports done.
// Latency: one cycle from an accepted payload byte to its load strobe; s_ready low while running, in DONE and in ERR.
// Backpressure: s_ready is a pure function of state, so an upstream source may hold s_valid high throughout.
module cpu_load_sequencer #(
  parameter int INSTR_DEPTH = 32,
  parameter int DATA_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] cpu_input,
  output logic [4:0] load_address,
  output logic       load,
  output logic       is_instruction,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_D, S_HDR_R, S_LOAD_I, S_LOAD_D, S_RUN, S_DONE, S_ERR
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] n_i, n_d, run_cnt;
  logic [4:0] idx;
  logic       xfer, hdr_bad, last_i, last_d;

  assign xfer    = s_valid && s_ready;
  assign hdr_bad = (n_i == 8'd0) || ({1'b0, n_i} > 9'(INSTR_DEPTH)) || ({1'b0, n_d} > 9'(DATA_DEPTH));
  assign last_i  = ({3'b000, idx} == (n_i - 8'd1));
  assign last_d  = ({3'b000, idx} == (n_d - 8'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (xfer) state_nxt = S_HDR_D;
      end
      S_HDR_D: begin
        s_ready = 1'b1;
        if (xfer) state_nxt = S_HDR_R;
      end
      S_HDR_R: begin
        s_ready = 1'b1;
        if (xfer) state_nxt = hdr_bad ? S_ERR : S_LOAD_I;
      end
      S_LOAD_I: begin
        s_ready = 1'b1;
        if (xfer && last_i) state_nxt = (n_d == 8'd0) ? S_RUN : S_LOAD_D;
      end
      S_LOAD_D: begin
        s_ready = 1'b1;
        if (xfer && last_d) state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        if (run_cnt == 8'd0) state_nxt = S_DONE;
      end
      // busy drops together with the done pulse so a poller sees a clean handoff
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_i            <= 8'd0;
      n_d            <= 8'd0;
      run_cnt        <= 8'd0;
      idx            <= 5'd0;
      load           <= 1'b0;
      cpu_input      <= 8'd0;
      load_address   <= 5'd0;
      is_instruction <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        S_IDLE:  if (xfer) n_i <= s_data;
        S_HDR_D: if (xfer) n_d <= s_data;
        S_HDR_R: if (xfer) begin
          run_cnt <= s_data;
          idx     <= 5'd0;
        end
        S_LOAD_I, S_LOAD_D: if (xfer) begin
          load           <= 1'b1;
          cpu_input      <= s_data;
          load_address   <= (state == S_LOAD_I) ? idx : {1'b0, idx[3:0]};
          is_instruction <= (state == S_LOAD_I);
          idx            <= (state == S_LOAD_I && last_i) ? 5'd0 : idx + 5'd1;
        end
        S_RUN: if (run_cnt != 8'd0) run_cnt <= run_cnt - 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_load_sequencer.sv
// Scoreboard bench for cpu_load_sequencer: expected strobes are queued as bytes are sent and popped on each load.
module tb_cpu_load_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] cpu_input;
  logic [4:0] load_address;
  logic       load, is_instruction, cpu_reset, busy, done, error;

  cpu_load_sequencer #(.INSTR_DEPTH(32), .DATA_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cpu_input(cpu_input), .load_address(load_address), .load(load),
    .is_instruction(is_instruction), .cpu_reset(cpu_reset), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_strobes = 0, low_cnt = 0, done_cnt = 0;
  int first_low_cyc = 0, first_strobe_cyc = 0, last_strobe_cyc = 0;
  logic [13:0] exp_q[$];
  logic [7:0]  pl_q[$];
  logic [13:0] mon_exp;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (load) begin
      if (n_strobes == 0) first_strobe_cyc = cyc;
      n_strobes++;
      last_strobe_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe got instr=%0b addr=%0d data=%h required none", is_instruction, load_address, cpu_input);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({is_instruction, load_address, cpu_input} !== mon_exp) begin
          n_bad++;
          $display("FAIL strobe got instr=%0b addr=%0d data=%h required instr=%0b addr=%0d data=%h",
                   is_instruction, load_address, cpu_input, mon_exp[13], mon_exp[12:8], mon_exp[7:0]);
        end
      end
    end
    if (!cpu_reset) begin
      if (low_cnt == 0) first_low_cyc = cyc;
      low_cnt++;
    end
    if (done) begin
      done_cnt++;
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_at_done got %0b required 0", busy);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    n_strobes = 0; low_cnt = 0; done_cnt = 0;
    first_low_cyc = 0; first_strobe_cyc = 0; last_strobe_cyc = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    int t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready got %0b required 1", s_ready);
    end
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if ({cpu_input, load_address, load, is_instruction, cpu_reset, busy, done, error, s_ready}
        !== {8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL %s got in=%h addr=%0d ld=%0b ins=%0b crst=%0b busy=%0b done=%0b err=%0b rdy=%0b required 00/0/0/0/1/0/0/0/1",
               name, cpu_input, load_address, load, is_instruction, cpu_reset, busy, done, error, s_ready);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check_reset_values("reset_values");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    clear_stats();
  endtask

  task automatic wait_done(input int r, input int nstr, input bit gaps, input string name);
    int t = 0;
    while (!done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done_timeout got done=%0b required 1", name, done);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, s_ready, cpu_reset} !== 3'b011) begin
      n_bad++;
      $display("FAIL %s_after_done got done=%0b rdy=%0b crst=%0b required 0/1/1", name, done, s_ready, cpu_reset);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL %s_done_pulses got %0d required 1", name, done_cnt);
    end
    n_cmp++;
    if (low_cnt != r + 1) begin
      n_bad++;
      $display("FAIL %s_run_cycles got %0d required %0d", name, low_cnt, r + 1);
    end
    n_cmp++;
    if (n_strobes != nstr || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_strobe_count got %0d (left %0d) required %0d (left 0)", name, n_strobes, exp_q.size(), nstr);
    end
    n_cmp++;
    if (first_low_cyc < last_strobe_cyc) begin
      n_bad++;
      $display("FAIL %s_release_order got release cyc %0d required >= last strobe cyc %0d", name, first_low_cyc, last_strobe_cyc);
    end
    n_cmp++;
    if (last_strobe_cyc - first_strobe_cyc != (gaps ? 2 : 1) * (nstr - 1)) begin
      n_bad++;
      $display("FAIL %s_strobe_spacing got %0d required %0d", name, last_strobe_cyc - first_strobe_cyc, (gaps ? 2 : 1) * (nstr - 1));
    end
  endtask

  task automatic run_frame(input int ni, input int nd, input int r, input bit gaps, input string name);
    clear_stats();
    send(8'(ni)); if (gaps) @(negedge clk);
    send(8'(nd)); if (gaps) @(negedge clk);
    send(8'(r));  if (gaps) @(negedge clk);
    for (int k = 0; k < ni + nd; k++) begin
      if (k < ni) exp_q.push_back({1'b1, 5'(k), pl_q[k]});
      else        exp_q.push_back({1'b0, 5'(k - ni), pl_q[k]});
      send(pl_q[k]);
      if (gaps) @(negedge clk);
    end
    wait_done(r, ni + nd, gaps, name);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset_hold");
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset_release");
    clear_stats();
  endtask

  task automatic test_nominal();
    pl_q = '{8'hA1, 8'hB2, 8'h55};
    run_frame(2, 1, 3, 1'b0, "nominal");
  endtask

  task automatic test_back_to_back();
    pl_q = '{8'h7F};
    run_frame(1, 0, 0, 1'b0, "nd_zero_b2b");
  endtask

  task automatic test_gaps();
    pl_q = '{8'hA1, 8'hB2, 8'h55};
    run_frame(2, 1, 3, 1'b1, "gaps");
  endtask

  task automatic test_full_depth();
    pl_q.delete();
    for (int k = 0; k < 48; k++) pl_q.push_back(8'((k * 37 + 11) ^ 8'h5A));
    run_frame(32, 16, 255, 1'b0, "full_depth");
  endtask

  task automatic test_bad_header();
    logic [23:0] hdrs [3];
    hdrs[0] = 24'h000000;
    hdrs[1] = 24'h210000;
    hdrs[2] = 24'h011100;
    for (int h = 0; h < 3; h++) begin
      apply_reset();
      send(hdrs[h][23:16]);
      send(hdrs[h][15:8]);
      send(hdrs[h][7:0]);
      n_cmp++;
      if ({error, s_ready, busy} !== 3'b100) begin
        n_bad++;
        $display("FAIL bad_header%0d got err=%0b rdy=%0b busy=%0b required 1/0/0", h, error, s_ready, busy);
      end
      s_data  = 8'h99;
      s_valid = 1'b1;
      repeat (5) @(negedge clk);
      s_valid = 1'b0;
      n_cmp++;
      if ({error, s_ready, cpu_reset} !== 3'b101 || n_strobes != 0) begin
        n_bad++;
        $display("FAIL bad_header%0d_sticky got err=%0b rdy=%0b crst=%0b strobes=%0d required 1/0/1/0",
                 h, error, s_ready, cpu_reset, n_strobes);
      end
    end
    apply_reset();
    n_cmp++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL error_cleared got %0b required 0", error);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_stats();
    send(8'h03);
    send(8'h00);
    send(8'h00);
    exp_q.push_back({1'b1, 5'd0, 8'hC3});
    send(8'hC3);
    @(negedge clk);
    n_cmp++;
    if (n_strobes != 1 || cpu_reset !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_frame_state got strobes=%0d crst=%0b busy=%0b required 1/1/1", n_strobes, cpu_reset, busy);
    end
    apply_reset();
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_frame(2, 1, 3, 1'b0, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_gaps();
    test_full_depth();
    test_bad_header();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
